fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage for the pipelined RISC-V core. It owns the program counter and issues addresses to a synchronous-read instruction memory. Returned instructions go into a small fetch queue, which feeds the IF/ID boundary through a valid/ready handshake. Taken branches and jumps resolved downstream arrive as a single redirect that flushes all fetched-but-unconsumed work.

## Interface
Parameters:
- WIDTH, 32: PC/address and instruction width.
- DEPTH, 2: fetch-queue entries; legal range 2..8.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  WIDTH  read address; equals the current PC.
- imem_rdata  in  WIDTH  instruction; valid exactly one cycle after an accepted request.
- redirect_valid  in  1  taken branch/jump from EX (branch & zero or jump).
- redirect_pc  in  WIDTH  target address.
- if_valid  out  1  head entry is presented to decode.
- if_ready  in  1  decode accepts the head entry (stall when 0).
- if_pc  out  WIDTH  PC of the head entry.
- if_inst  out  WIDTH  instruction of the head entry.
- if_pc_plus4  out  WIDTH  if_pc + 4.

## Operation
- State:
  - pc register.
  - inflight flag: one request outstanding.
  - fetch queue of {pc, inst} entries with count 0..DEPTH.
  - drop flag: discard the next response.
- pop = if_valid & if_ready.
- Issue condition: !rst & !redirect_valid & (count + inflight − pop) < DEPTH. When true: imem_req=1, imem_addr=pc, pc <= pc + 4 (modulo 2^WIDTH, wraps silently), inflight <= 1, and the issued pc is latched for the response.
- Response:
  - In the cycle after an issue, imem_rdata is pushed with its latched pc, unless drop is set.
  - When drop is set, the response is discarded and drop clears.
- Push and pop in the same cycle are legal at any count. count is unchanged; head advances and tail writes.
- if_valid = (count != 0). Outputs come from the head entry only; there is no bypass from imem_rdata.
- Redirect (highest priority after rst):
  - pc <= redirect_pc, count <= 0, no issue this cycle.
  - If a response is due next cycle, drop <= 1.
  - A pop presented in the same cycle is still accepted by decode; the queue is emptied regardless.
- Redirect while the queue is empty and nothing is in flight: only the pc load occurs.
- Back-to-back redirects: the last one wins. drop does not double-count, because no issue occurs during a redirect cycle.
- Reset: pc=RESET_PC, count=0, inflight=0, drop=0, imem_req=0, if_valid=0. Outputs if_pc/if_inst/if_pc_plus4 = 0. Reset mid-operation discards all queue contents and any in-flight response.
- Misaligned redirect_pc is passed through unchanged; alignment checking belongs to EX.

## Timing
- Cycle 0 after rst deasserts: issue RESET_PC.
- Cycle 1: response pushed.
- Cycle 2: if_valid=1 with if_pc=RESET_PC. First-fetch latency is 2 cycles.
- Steady state with if_ready held high: one instruction per cycle. DEPTH≥2 is required for this.
- Redirect at cycle t: issue of redirect_pc at t+1; if_valid at t+3 for the target.
- Stall (if_ready=0): the queue fills to DEPTH, then issue stops. No instruction is lost or duplicated.

## Configuration
- FETCH_PERF_CNT_EN defined: adds two outputs, both reset to 0 and wrapping on overflow.
  - perf_bubble_cnt (32 bits): counts cycles with if_valid=0 and rst=0.
  - perf_flush_cnt (32 bits): counts cycles with redirect_valid=1.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

## Structure
- riscv_pkg holds: XLEN=32, the default RESET_PC, INST_NOP=32'h0000_0013, and the fetch-entry struct {pc, inst}.
- One sub-module: fetch_queue.
  - Synchronous FIFO, parameters WIDTH and DEPTH.
  - Ports: push, pop, flush, head outputs, count.
  - Head/tail pointers wrap modulo DEPTH.
- The top level holds the pc, inflight and drop logic, plus the perf counters.

## Test plan
- Reset release, memory returns addr-derived words, if_ready=1 → if_valid rises 2 cycles after reset; if_pc sequence 0x0,0x4,0x8… one per cycle; if_pc_plus4=if_pc+4.
- Hold if_ready=0 for 10 cycles → count saturates at DEPTH; imem_req=0 once full; on release, pcs continue contiguously with no gap or repeat.
- redirect_valid with redirect_pc=0x100 while a request is in flight → stale response dropped; next if_pc=0x100 three cycles later; no old pc appears.
- Redirect coincident with pop, and two redirects on consecutive cycles (0x200 then 0x300) → the popped entry is consumed once; the stream resumes at 0x300 only.
- Assert rst mid-stream with a full queue → next cycle if_valid=0, imem_req=0; fetch restarts at RESET_PC.
- With FETCH_PERF_CNT_EN: 3-cycle stall-free start, then one redirect → perf_bubble_cnt=2 before the redirect bubbles are added; perf_flush_cnt=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and types for the pipelined RISC-V core:
//               architectural width, reset vector, canonical NOP encoding and
//               the fetch-queue entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Small synchronous FIFO holding fetched {pc, inst} pairs.
//               Push and pop in the same cycle are accepted at any fill level,
//               including full. Flush empties the queue and takes priority
//               over push and pop.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               flush           - discard all entries
//               push, push_pc,
//               push_inst       - write one entry at the tail
//               pop             - consume the head entry
//               head_pc,
//               head_inst       - head entry (undefined when count == 0)
//               count           - number of valid entries, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_pc,
  input  logic [WIDTH-1:0]             push_inst,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_pc,
  output logic [WIDTH-1:0]             head_inst,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH+1);
  localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH-1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [WIDTH-1:0]   r_pc_mem   [DEPTH];
  logic [WIDTH-1:0]   r_inst_mem [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST_PTR) ? '0 : p + c_PTR_ONE;
  endfunction

  always_comb begin
    w_do_pop  = pop & (r_count != '0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    w_do_push = push & ((r_count != c_FULL) | w_do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_pc_mem[r_wr_ptr]   <= push_pc;
        r_inst_mem[r_wr_ptr] <= push_inst;
        r_wr_ptr             <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_pc   = r_pc_mem[r_rd_ptr];
  assign head_inst = r_inst_mem[r_rd_ptr];
  assign count     = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, issues reads to a
//               synchronous-read instruction memory (data one cycle after the
//               request), buffers responses in fetch_queue and presents the
//               head entry to decode via valid/ready. A redirect from EX
//               reloads the PC and flushes all fetched-but-unconsumed work.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               imem_req, imem_addr      - read request / address (= pc)
//               imem_rdata               - read data, one cycle after request
//               redirect_valid,
//               redirect_pc              - taken branch/jump target
//               if_valid, if_ready       - decode handshake
//               if_pc, if_inst,
//               if_pc_plus4              - head entry (zero when empty)
//               perf_bubble_cnt,
//               perf_flush_cnt           - only with FETCH_PERF_CNT_EN
// Options     : FETCH_PERF_CNT_EN - adds bubble/flush performance counters
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import riscv_pkg::*;
#(
  parameter int               WIDTH    = XLEN,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_inst,
  output logic [WIDTH-1:0] if_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_bubble_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  localparam int c_CNT_W = $clog2(DEPTH+1);
  localparam int c_OCC_W = c_CNT_W + 1;
  localparam logic [WIDTH-1:0]   c_FOUR  = WIDTH'(4);
  localparam logic [c_OCC_W-1:0] c_DEPTH = c_OCC_W'(DEPTH);

  logic [WIDTH-1:0]   r_pc;
  logic [WIDTH-1:0]   r_resp_pc;
  logic               r_inflight;
  logic               r_drop;

  logic [c_CNT_W-1:0] w_count;
  logic [WIDTH-1:0]   w_head_pc;
  logic [WIDTH-1:0]   w_head_inst;
  logic               w_pop;
  logic               w_issue;
  logic               w_push;
  logic [c_OCC_W-1:0] w_occ;

  always_comb begin
    w_pop  = if_valid & if_ready;
    // Occupancy the queue will have once the outstanding response lands;
    // a new issue is only allowed if its response is guaranteed a slot.
    w_occ  = {1'b0, w_count} + {{c_CNT_W{1'b0}}, r_inflight}
           - {{c_CNT_W{1'b0}}, w_pop};
    w_issue = !rst && !redirect_valid && (w_occ < c_DEPTH);
    // A response arriving in a redirect cycle is discarded by the flush.
    w_push = r_inflight & !r_drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_resp_pc  <= '0;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (redirect_valid) begin
        r_pc <= redirect_pc;
      end else if (w_issue) begin
        r_pc <= r_pc + c_FOUR;
      end
      if (w_issue) begin
        r_resp_pc <= r_pc;
      end
      // Drop the next response only if one is due in the following cycle;
      // a redirect suppresses issue, so a pending drop never double-counts.
      if (redirect_valid && w_issue) begin
        r_drop <= 1'b1;
      end else if (r_inflight && r_drop) begin
        r_drop <= 1'b0;
      end
    end
  end

  fetch_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (w_push),
    .push_pc   (r_resp_pc),
    .push_inst (imem_rdata),
    .pop       (w_pop),
    .head_pc   (w_head_pc),
    .head_inst (w_head_inst),
    .count     (w_count)
  );

  assign imem_req    = w_issue;
  assign imem_addr   = r_pc;
  assign if_valid    = (w_count != '0);
  assign if_pc       = if_valid ? w_head_pc : '0;
  assign if_inst     = if_valid ? w_head_inst : '0;
  assign if_pc_plus4 = if_valid ? (w_head_pc + c_FOUR) : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (!if_valid) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
      if (redirect_valid) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign perf_bubble_cnt = r_bubble_cnt;
  assign perf_flush_cnt  = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A queue-level model of the
//               fetch stage predicts every output each cycle; directed
//               scenarios pin literal values, then randomized ready/redirect/
//               reset traffic runs against the model.
// Options     : FETCH_PERF_CNT_EN - also checks the performance counters
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam int          DEPTH    = 3;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] if_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .WIDTH    (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_pc_plus4    (if_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_bubble_cnt (perf_bubble_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction word derived from its address so a wrong pairing shows up.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  // Synchronous-read memory; garbage when no request so stray pushes show.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? word_of(imem_addr) : $urandom();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_bubble;
  logic [31:0] m_flush;

  initial begin : compare
    logic m_valid;
    logic m_pop;
    logic m_req;
    @(posedge clk);
    m_q.delete();
    m_pc = RESET_PC; m_pend = 1'b0; m_pend_pc = '0; m_bubble = '0; m_flush = '0;
    forever begin
      @(negedge clk);
      #2;
      m_valid = (m_q.size() != 0);
      m_pop   = m_valid && if_ready;
      m_req   = !rst && !redirect_valid &&
                ((m_q.size() + (m_pend ? 1 : 0) - (m_pop ? 1 : 0)) < DEPTH);
      chk("m_if_valid", {31'b0, if_valid}, {31'b0, m_valid});
      chk("m_imem_req", {31'b0, imem_req}, {31'b0, m_req});
      if (m_req) chk("m_imem_addr", imem_addr, m_pc);
      if (m_valid) begin
        chk("m_if_pc", if_pc, m_q[0]);
        chk("m_if_inst", if_inst, word_of(m_q[0]));
        chk("m_if_pc_plus4", if_pc_plus4, m_q[0] + 32'd4);
      end else begin
        chk("m_if_pc_idle", if_pc, 32'h0);
        chk("m_if_pc_plus4_idle", if_pc_plus4, 32'h0);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("m_perf_bubble", perf_bubble_cnt, m_bubble);
      chk("m_perf_flush", perf_flush_cnt, m_flush);
`endif
      @(posedge clk);
      if (rst) begin
        m_q.delete();
        m_pc = RESET_PC; m_pend = 1'b0; m_bubble = '0; m_flush = '0;
      end else begin
        if (!m_valid) m_bubble = m_bubble + 32'd1;
        if (redirect_valid) begin
          m_flush = m_flush + 32'd1;
          m_q.delete();
          m_pend = 1'b0;
          m_pc   = redirect_pc;
        end else begin
          if (m_pop) void'(m_q.pop_front());
          if (m_pend) m_q.push_back(m_pend_pc);
          m_pend = m_req;
          if (m_req) begin
            m_pend_pc = m_pc;
            m_pc      = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    #3;
  endtask

  initial begin : stim
    logic [31:0] tgt;
    repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);

    // first fetch: issue at cycle 0, visible at cycle 2
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("c0_req", {31'b0, imem_req}, 32'h1);
    chk("c0_addr", imem_addr, 32'h0);
    chk("c0_valid", {31'b0, if_valid}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("c1_valid", {31'b0, if_valid}, 32'h0);
    chk("c1_addr", imem_addr, 32'h4);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("c2_valid", {31'b0, if_valid}, 32'h1);
    chk("c2_pc", if_pc, 32'h0);
    chk("c2_plus4", if_pc_plus4, 32'h4);
    chk("c2_inst", if_inst, word_of(32'h0));
`ifdef FETCH_PERF_CNT_EN
    chk("c2_perf_bubble", perf_bubble_cnt, 32'd2);
`endif
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("c3_pc", if_pc, 32'h4);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("c4_pc", if_pc, 32'h8);

    // stall for 10 cycles
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      if (i == 0) chk("stall_head", if_pc, 32'hC);
    end
    chk("stall_full_req", {31'b0, imem_req}, 32'h0);
    chk("stall_hold_pc", if_pc, 32'hC);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("release_pc0", if_pc, 32'hC);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("release_pc1", if_pc, 32'h10);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("release_pc2", if_pc, 32'h14);

    // redirect with a request in flight
    cyc(1'b0, 1'b1, 32'h100, 1'b1);
    chk("redir_no_req", {31'b0, imem_req}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_t1_addr", imem_addr, 32'h100);
    chk("redir_t1_req", {31'b0, imem_req}, 32'h1);
    chk("redir_t1_valid", {31'b0, if_valid}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_t2_valid", {31'b0, if_valid}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_t3_pc", if_pc, 32'h100);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b1);

    // redirect coincident with pop, then back-to-back redirect
    cyc(1'b0, 1'b1, 32'h200, 1'b1);
    chk("redir_pop_valid", {31'b0, if_valid}, 32'h1);
    cyc(1'b0, 1'b1, 32'h300, 1'b1);
    chk("b2b_no_req", {31'b0, imem_req}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("b2b_addr", imem_addr, 32'h300);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("b2b_pc", if_pc, 32'h300);

    // reset mid-stream with a full queue
    repeat (5) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("prerst_valid", {31'b0, if_valid}, 32'h1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("midrst_valid", {31'b0, if_valid}, 32'h0);
    chk("midrst_req", {31'b0, imem_req}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("restart_addr", imem_addr, RESET_PC);
    chk("restart_req", {31'b0, imem_req}, 32'h1);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      tgt = $urandom();
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 4) == 0) tgt = 32'hFFFF_FFF8;
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 19) == 0),
          tgt,
          ($urandom_range(0, 9) < 7));
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
